// File: rtl/mod_reduce_sched_if.sv
// Bundle between the scheduler, its requesters and the shared modular reducer.
interface mod_reduce_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 13,
    parameter int unsigned MW   = 12,
    parameter int unsigned RW   = 13
) ();
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic [MW-1:0]     cfg_modulus;
    logic              red_start;
    logic [W-1:0]      red_n;
    logic [MW-1:0]     red_m;
    logic              red_done;
    logic [RW-1:0]     red_result;
    logic              sched_busy;

    // slave: the scheduler itself; master: requesters plus reducer environment
    modport slave (
        input  req, req_data, cfg_modulus, red_done, red_result,
        output ack, rsp_valid, rsp_data, rsp_err, red_start, red_n, red_m, sched_busy
    );

    modport master (
        output req, req_data, cfg_modulus, red_done, red_result,
        input  ack, rsp_valid, rsp_data, rsp_err, red_start, red_n, red_m, sched_busy
    );
endinterface

// File: rtl/mod_reduce_sched.sv
// Round-robin scheduler sharing one modular-reduction unit between NREQ requesters,
// with a post-reset drain window and a watchdog on the unreset reducer.
module mod_reduce_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 13,
    parameter int unsigned MW   = 12,
    parameter int unsigned RW   = 13,
    parameter int unsigned TMO  = 1023
) (
    input logic              clk,
    input logic              rst_n,
    mod_reduce_sched_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WW = $clog2(TMO + 1);

    typedef enum logic [2:0] {StSync, StIdle, StIssue, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [RW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            red_start_q, red_start_d;
    logic [W-1:0]    red_n_q, red_n_d;
    logic [MW-1:0]   red_m_q, red_m_d;
    logic            busy_q, busy_d;

    logic [W-1:0]    ops [NREQ];
    logic [PW-1:0]   pick;
    logic [PW-1:0]   pick_next;

    for (genvar g = 0; g < NREQ; g++) begin : g_ops
        assign ops[g] = bus.req_data[g*W +: W];
    end

    // First set request at or after ptr, scanning cyclically.
    function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] ptr);
        logic [PW-1:0] p;
        logic [31:0]   c;
        p = ptr;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            c = (32'(ptr) + unsigned'(i)) % NREQ;
            if (r[PW'(c)]) p = PW'(c);
        end
        return p;
    endfunction

    assign pick      = rr_pick(bus.req, rr_q);
    assign pick_next = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        wdog_d      = wdog_q;
        ack_d       = '0;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        red_start_d = 1'b0;
        red_n_d     = red_n_q;
        red_m_d     = red_m_q;

        unique case (state_q)
            StSync: begin
                // Any completion seen here belongs to an operation from before reset.
                if (bus.red_done || wdog_q == WW'(TMO)) begin
                    state_d = StIdle;
                    wdog_d  = '0;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            StIdle: begin
                if (|bus.req) begin
                    state_d     = StIssue;
                    grant_d     = pick;
                    ack_d[pick] = 1'b1;
                    red_start_d = 1'b1;
                    red_n_d     = ops[pick];
                    red_m_d     = bus.cfg_modulus;
                    rr_d        = pick_next;
                end
            end
            StIssue: begin
                state_d = StWait;
                wdog_d  = '0;
            end
            StWait: begin
                wdog_d = wdog_q + WW'(1);
                if (bus.red_done) begin
                    state_d              = StResp;
                    rsp_data_d           = bus.red_result;
                    rsp_err_d            = 1'b0;
                    rsp_valid_d[grant_q] = 1'b1;
                end else if (wdog_q == WW'(TMO)) begin
                    state_d              = StResp;
                    rsp_data_d           = '0;
                    rsp_err_d            = 1'b1;
                    rsp_valid_d[grant_q] = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StSync;
                wdog_d  = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSync;
            rr_q        <= '0;
            grant_q     <= '0;
            wdog_q      <= '0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            red_start_q <= 1'b0;
            red_n_q     <= '0;
            red_m_q     <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_q     <= grant_d;
            wdog_q      <= wdog_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            red_start_q <= red_start_d;
            red_n_q     <= red_n_d;
            red_m_q     <= red_m_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.red_start  = red_start_q;
    assign bus.red_n      = red_n_q;
    assign bus.red_m      = red_m_q;
    assign bus.sched_busy = busy_q;
endmodule
